// File: rtl/ss_scan_mux.sv
// Four-digit 7-segment scan multiplexer with per-frame snapshot of the digit patterns.
// Define SEG_SCAN_BLANK_EN to insert BLANK_CYC blanking cycles after every digit slot.
module ss_scan_mux #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] ss3,
  input  logic [6:0] ss2,
  input  logic [6:0] ss1,
  input  logic [6:0] ss0,
  output logic [6:0] seg_out,
  output logic [3:0] an_out,
  output logic [1:0] digit_idx,
  output logic       frame_tick
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int PW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [PW-1:0] SCAN_LAST = PW'(SCAN_DIV - 1);
`ifdef SEG_SCAN_BLANK_EN
  localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYC - 1);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2
`ifdef SEG_SCAN_BLANK_EN
    , BLANK = 2'd3
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0][6:0] shadow_q, shadow_d;

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    if (!en) begin
      // Disabling idles the block but keeps the last snapshot.
      state_d = IDLE;
      presc_d = '0;
      idx_d   = 2'd0;
    end else begin
      case (state_q)
        IDLE: state_d = LOAD;
        LOAD: begin
          shadow_d = {ss3, ss2, ss1, ss0};
          idx_d    = 2'd0;
          presc_d  = '0;
          state_d  = SCAN;
        end
        SCAN: begin
          if (presc_q == SCAN_LAST) begin
            presc_d = '0;
`ifdef SEG_SCAN_BLANK_EN
            state_d = BLANK;
`else
            if (idx_q == 2'd3) begin
              idx_d   = 2'd0;
              state_d = LOAD;
            end else begin
              idx_d = idx_q + 2'd1;
            end
`endif
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
`ifdef SEG_SCAN_BLANK_EN
        BLANK: begin
          if (presc_q == BLANK_LAST) begin
            presc_d = '0;
            if (idx_q == 2'd3) begin
              idx_d   = 2'd0;
              state_d = LOAD;
            end else begin
              idx_d   = idx_q + 2'd1;
              state_d = SCAN;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      idx_q    <= 2'd0;
      shadow_q <= {4{7'h7F}};
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
    end
  end

  // Outputs decode straight from the registers so they move on the state edge.
  always_comb begin
    seg_out    = 7'h7F;
    an_out     = 4'hF;
    digit_idx  = 2'd0;
    frame_tick = 1'b0;
    case (state_q)
      LOAD: frame_tick = 1'b1;
      SCAN: begin
        seg_out   = shadow_q[idx_q];
        an_out    = ~(4'b0001 << idx_q);
        digit_idx = idx_q;
      end
`ifdef SEG_SCAN_BLANK_EN
      BLANK: digit_idx = idx_q;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ss_scan_mux.sv
// Scoreboard bench for ss_scan_mux: expected per-cycle outputs are queued with the stimulus
// and compared one per clock; also handles the SEG_SCAN_BLANK_EN build.
module tb_ss_scan_mux;
  localparam int SD = 4;
  localparam int BC = 2;
`ifdef SEG_SCAN_BLANK_EN
  localparam int SLOT = SD + BC;
`else
  localparam int SLOT = SD;
`endif
  localparam int FRAME = 4 * SLOT + 1;
  localparam logic [13:0] BLANK_OUT = {1'b0, 2'd0, 4'hF, 7'h7F};

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [6:0] ss3, ss2, ss1, ss0;
  logic [6:0] seg_out;
  logic [3:0] an_out;
  logic [1:0] digit_idx;
  logic       frame_tick;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_tick = -1;
  logic [13:0] exp_q[$];

  always #10 clk = ~clk;

  ss_scan_mux #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst(rst), .en(en),
    .ss3(ss3), .ss2(ss2), .ss1(ss1), .ss0(ss0),
    .seg_out(seg_out), .an_out(an_out), .digit_idx(digit_idx), .frame_tick(frame_tick)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {tick, idx, an, seg} at position k of a frame whose snapshot is s3..s0.
  function automatic logic [13:0] exp_at(input int k, input logic [6:0] s0, input logic [6:0] s1,
                                         input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] pat [4];
    int j, d, r;
    logic [1:0] di;
    pat[0] = s0; pat[1] = s1; pat[2] = s2; pat[3] = s3;
    if (k == 0) return {1'b1, 2'd0, 4'hF, 7'h7F};
    j = k - 1;
    d = j / SLOT;
    r = j % SLOT;
    di = d[1:0];
    if (r < SD) return {1'b0, di, ~(4'b0001 << di), pat[d]};
    return {1'b0, di, 4'hF, 7'h7F};
  endfunction

  task automatic push_part(input int lo, input int hi, input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3);
    for (int k = lo; k < hi; k++) exp_q.push_back(exp_at(k, s0, s1, s2, s3));
  endtask

  task automatic drain();
    logic [13:0] e;
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      cyc++;
      e = exp_q.pop_front();
      $display("cyc %0d: tick=%0b idx=%0d an=%h seg=%h (exp %h)", cyc, frame_tick, digit_idx,
               an_out, seg_out, e);
      chk("scan_out", {18'd0, frame_tick, digit_idx, an_out, seg_out}, {18'd0, e});
      if (frame_tick) begin
        if (last_tick >= 0) chk("tick_gap", cyc - last_tick, FRAME);
        last_tick = cyc;
      end
    end
  endtask

  task automatic chk_blank(input string tag);
    chk(tag, {18'd0, frame_tick, digit_idx, an_out, seg_out}, {18'd0, BLANK_OUT});
  endtask

  initial begin
    rst = 1'b0; en = 1'b0;
    ss0 = 7'h7F; ss1 = 7'h7F; ss2 = 7'h7F; ss3 = 7'h7F;
    #5 chk_blank("reset_async");
    @(posedge clk); #1;
    chk_blank("reset_edge");

    // Basic scan
    rst = 1'b1; en = 1'b1;
    ss0 = 7'h40; ss1 = 7'h79; ss2 = 7'h24; ss3 = 7'h30;
    push_part(0, FRAME, 7'h40, 7'h79, 7'h24, 7'h30);
    drain();

    // Snapshot: change ss1 while digit 2 is lit
    push_part(0, 2 * SLOT + 2, 7'h40, 7'h79, 7'h24, 7'h30);
    drain();
    ss1 = 7'h19;
    push_part(2 * SLOT + 2, FRAME, 7'h40, 7'h79, 7'h24, 7'h30);
    drain();

    // Next frame shows new digit 1; drop en on cycle 2 of digit 2
    push_part(0, 2 * SLOT + 3, 7'h40, 7'h19, 7'h24, 7'h30);
    drain();
    en = 1'b0;
    last_tick = -1;
    for (int i = 0; i < 3; i++) exp_q.push_back(BLANK_OUT);
    drain();
    en = 1'b1;
    push_part(0, SLOT + 2, 7'h40, 7'h19, 7'h24, 7'h30);
    drain();

    // Async reset at mid-period during digit 1
    #9 rst = 1'b0;
    #1 chk_blank("rst_mid_async");
    @(posedge clk); #1;
    chk_blank("rst_mid_edge");
    rst = 1'b1;
    last_tick = -1;
    push_part(0, FRAME, 7'h40, 7'h19, 7'h24, 7'h30);
    push_part(0, 1, 7'h40, 7'h19, 7'h24, 7'h30);
    drain();

    en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ss_scan_mux.md
Name: ss_scan_mux

Overview:
- Downstream display stage for the four-digit counter/display block that produces four 7-segment patterns (ss3..ss0).
- Time-multiplexes those four patterns onto one shared segment bus with per-digit anode enables, so the board can drive a common-segment 4-digit display.
- Captures a coherent snapshot of all four digits once per frame, so a scan never mixes old and new values (no tearing).

Parameters:
- SCAN_DIV, 50000: clk cycles each digit is lit (1 ms at 50 MHz); legal range >= 1.
- BLANK_CYC, 16: clk cycles of inter-digit blanking; used only with SEG_SCAN_BLANK_EN; legal range >= 1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset; asynchronous, active-low (0 = reset).
- en  input  1  scan enable; 0 blanks the display and idles the block.
- ss3  input  7  segment pattern, digit 3 (leftmost); active-low, bit0 = seg a.
- ss2  input  7  segment pattern, digit 2; active-low.
- ss1  input  7  segment pattern, digit 1; active-low.
- ss0  input  7  segment pattern, digit 0 (rightmost); active-low.
- seg_out  output  7  shared segment bus; active-low.
- an_out  output  4  digit enables; active-low, one-hot-low or all 1s; bit n = digit n.
- digit_idx  output  2  index of the digit currently lit.
- frame_tick  output  1  one-cycle pulse at the start of each frame.

Behaviour:
- State registers: FSM state, prescaler, digit index, and four 7-bit shadow registers.
- Outputs are Moore decodes of these registers. They change on the same edge as the state change, with no extra pipeline stage.
- FSM states:
  - IDLE: seg_out = 7'h7F, an_out = 4'hF, digit_idx = 0, frame_tick = 0.
  - LOAD: lasts one cycle.
    - Captures ss0..ss3 into the shadow registers; sets index = 0, prescaler = 0.
    - Outputs blank; frame_tick = 1.
  - SCAN: seg_out = shadow[index]; an_out has bit[index] = 0 and all others = 1; digit_idx = index.
  - BLANK (feature only): outputs blank; digit_idx holds the digit just shown.
- Transitions:
  - IDLE -> LOAD when en = 1.
  - LOAD -> SCAN.
  - SCAN: prescaler counts 0..SCAN_DIV-1. On reaching SCAN_DIV-1:
    - if index < 3: index increments, prescaler clears, state stays SCAN;
    - if index = 3: state goes to LOAD (index wraps to 0).
  - Any state -> IDLE on the first edge sampling en = 0. Prescaler and index clear; shadow registers retain their contents.
  - Re-enable always restarts at LOAD with digit 0.
- Frame period without the feature: 4*SCAN_DIV + 1 cycles.
- frame_tick fires on every LOAD, including the first LOAD after IDLE.
- Inputs are sampled only in LOAD. Changes to ss* mid-frame appear at the next frame.
- Prescaler width: clog2 of max(SCAN_DIV, BLANK_CYC), minimum 1 bit. SCAN_DIV = 1 is legal: each digit is lit for exactly one cycle.
- Reset (rst = 0) takes effect immediately, independent of clk:
  - state = IDLE, prescaler = 0, index = 0;
  - shadow registers = 7'h7F;
  - seg_out = 7'h7F, an_out = 4'hF, digit_idx = 0, frame_tick = 0.
- Reset asserted mid-scan blanks the display immediately. After release, the block resumes via IDLE -> LOAD if en = 1.
- en = 0 and rst = 0 together: reset dominates.

Optional Feature:
- Macro: SEG_SCAN_BLANK_EN.
- When defined, every SCAN slot end goes to BLANK for BLANK_CYC cycles to suppress ghosting. Prescaler is reused. BLANK exit rules:
  - index < 3: index increments, state returns to SCAN;
  - index = 3: state goes to LOAD.
- Frame period with the feature: 4*(SCAN_DIV + BLANK_CYC) + 1 cycles.
- When undefined, the BLANK state and BLANK_CYC logic are absent, and behaviour is exactly as above.

Test Plan (clk period 20; SCAN_DIV = 4, BLANK_CYC = 2):
1. Reset: hold rst = 0 for 1 clock -> seg_out = 7F, an_out = F, digit_idx = 0, frame_tick = 0 throughout.
2. Basic scan: release rst; en = 1; ss0 = 40, ss1 = 79, ss2 = 24, ss3 = 30 -> expected sequence:
   - 1 LOAD cycle with frame_tick = 1 and blank outputs;
   - an = E / seg = 40 for 4 cycles;
   - an = D / 79 for 4 cycles;
   - an = B / 24 for 4 cycles;
   - an = 7 / 30 for 4 cycles;
   - next frame_tick exactly 17 cycles after the previous one.
3. Snapshot: while digit 2 is lit, set ss1 = 19 -> the current frame still shows 79 on digit 1; the next frame shows 19 on digit 1.
4. Enable drop: deassert en during cycle 2 of digit 2 -> blank (7F/F) from the next edge. Reassert en after 3 cycles -> LOAD (frame_tick = 1), then digit 0 for a full 4 cycles.
5. Async reset mid-scan: drive rst = 0 at mid-period during digit 1 -> seg_out = 7F and an_out = F before the next clk edge. After release with en = 1 -> LOAD on the first edge.
6. With SEG_SCAN_BLANK_EN: same stimulus as test 2 -> 2 blank cycles after each digit, including digit 3; frame_tick spacing = 25 cycles; digit_idx holds during each BLANK.
